// File: rtl/text_console_pkg.sv
// Shared definitions for the text console block.
//   - Glyph and visible-area geometry (8x16 glyphs, 640x480 visible).
//   - Control codes that the writer FSM interprets.
//   - Writer FSM state encoding.
//   - Helper that classifies printable bytes.
package text_console_pkg;

  localparam int CHAR_W = 8;
  localparam int CHAR_H = 16;
  localparam int H_VIS  = 640;
  localparam int V_VIS  = 480;

  localparam logic [7:0] LF    = 8'h0A;
  localparam logic [7:0] CR    = 8'h0D;
  localparam logic [7:0] BS    = 8'h08;
  localparam logic [7:0] FF    = 8'h0C;
  localparam logic [7:0] SPACE = 8'h20;

  typedef enum logic [1:0] {
    CLR_SCREEN = 2'd0,
    IDLE       = 2'd1,
    CLR_ROW    = 2'd2
  } state_t;

  function automatic logic is_printable(input logic [7:0] c);
    return (c >= 8'h20) && (c <= 8'h7E);
  endfunction

endpackage

// File: rtl/text_buffer_ram.sv
// Simple dual-port character buffer.
//   clk   : clock shared by both ports
//   we    : write enable (write port)
//   waddr : write cell index
//   wdata : byte to store
//   raddr : read cell index
//   rdata : byte at raddr, registered (1-cycle latency)
// A same-cell read and write in one cycle returns the previous contents.
module text_buffer_ram #(
  parameter int DEPTH = 2400,
  parameter int AW    = 12
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/text_console_ctrl.sv
// Text console controller.
// Accepts a byte stream (valid/ready), interprets control codes, tracks the
// cursor, clears the screen/rows, and serves glyph codes to the pixel
// renderer with one cycle of latency.
// Ports:
//   clk, reset                 : pixel clock, synchronous active-high reset
//   wr_valid/wr_char/wr_ready  : writer byte handshake
//   pix_x, pix_y, video_on_in  : pixel position and visible flag
//   frame_tick                 : one pulse per frame (cursor blink only)
//   char_code                  : character of the cell addressed last cycle
//   glyph_col, glyph_row       : pixel offset inside the glyph, delayed 1 cycle
//   video_on_out               : video_on_in delayed 1 cycle
//   cursor_hit                 : delayed cell is the cursor cell, blink phase on
//   cursor_col, cursor_row     : current cursor position
//   busy                       : a clear sweep is running
// Optional feature macro: TEXT_CONSOLE_CURSOR_BLINK_EN (cursor blink logic).
module text_console_ctrl #(
  parameter int COLS         = 80,
  parameter int ROWS         = 30,
  parameter int BLINK_FRAMES = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_valid,
  input  logic [7:0] wr_char,
  output logic       wr_ready,
  input  logic [9:0] pix_x,
  input  logic [9:0] pix_y,
  input  logic       video_on_in,
  input  logic       frame_tick,
  output logic [7:0] char_code,
  output logic [2:0] glyph_col,
  output logic [3:0] glyph_row,
  output logic       video_on_out,
  output logic       cursor_hit,
  output logic [6:0] cursor_col,
  output logic [4:0] cursor_row,
  output logic       busy
);
  import text_console_pkg::*;

  localparam int CELLS = COLS * ROWS;
  localparam int AW    = 12;
  localparam logic [AW-1:0] LAST_CELL = AW'(CELLS - 1);
  localparam logic [6:0]    LAST_COL  = 7'(COLS - 1);
  localparam logic [4:0]    LAST_ROW  = 5'(ROWS - 1);

  // row*80 + col as row*64 + row*16 + col, no multiplier.
  function automatic logic [AW-1:0] cell_index(input logic [4:0] r, input logic [6:0] c);
    return ({7'd0, r} << 6) + ({7'd0, r} << 4) + {5'd0, c};
  endfunction

  state_t        state, state_nx;
  logic [AW-1:0] idx, idx_nx;
  logic [6:0]    cur_col, col_nx;
  logic [4:0]    cur_row, row_nx;
  logic          advance;
  logic          accept;
  logic          we;
  logic [AW-1:0] waddr;
  logic [7:0]    wdata;

  assign busy       = (state != IDLE);
  assign wr_ready   = ~busy & ~reset;
  assign accept     = wr_valid & wr_ready;
  assign cursor_col = cur_col;
  assign cursor_row = cur_row;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= CLR_SCREEN;
      idx     <= '0;
      cur_col <= '0;
      cur_row <= '0;
    end else begin
      state   <= state_nx;
      idx     <= idx_nx;
      cur_col <= col_nx;
      cur_row <= row_nx;
    end
  end

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    col_nx   = cur_col;
    row_nx   = cur_row;
    advance  = 1'b0;
    we       = 1'b0;
    waddr    = cell_index(cur_row, cur_col);
    wdata    = SPACE;
    case (state)
      CLR_SCREEN: begin
        we    = 1'b1;
        waddr = idx;
        if (idx == LAST_CELL) begin
          state_nx = IDLE;
          idx_nx   = '0;
        end else begin
          idx_nx = idx + 1'b1;
        end
      end
      CLR_ROW: begin
        // cur_row already points at the row being blanked.
        we    = 1'b1;
        waddr = cell_index(cur_row, idx[6:0]);
        if (idx[6:0] == LAST_COL) begin
          state_nx = IDLE;
          idx_nx   = '0;
        end else begin
          idx_nx = idx + 1'b1;
        end
      end
      IDLE: begin
        if (accept) begin
          if (is_printable(wr_char)) begin
            we    = 1'b1;
            wdata = wr_char;
            if (cur_col == LAST_COL) advance = 1'b1;
            else                     col_nx  = cur_col + 7'd1;
          end else begin
            case (wr_char)
              LF: advance = 1'b1;
              CR: col_nx  = '0;
              BS: begin
                if (cur_col != 7'd0) begin
                  col_nx = cur_col - 7'd1;
                  we     = 1'b1;
                  waddr  = cell_index(cur_row, cur_col - 7'd1);
                end
              end
              FF: begin
                col_nx   = '0;
                row_nx   = '0;
                state_nx = CLR_SCREEN;
                idx_nx   = '0;
              end
              default: ;
            endcase
          end
          if (advance) begin
            col_nx   = '0;
            row_nx   = (cur_row == LAST_ROW) ? 5'd0 : cur_row + 5'd1;
            state_nx = CLR_ROW;
            idx_nx   = '0;
          end
        end
      end
      default: begin
        state_nx = CLR_SCREEN;
        idx_nx   = '0;
      end
    endcase
  end

  // Read path: pixel coordinates -> cell index; off-screen reads are
  // steered to cell 0 and blanked at the output.
  logic          in_vis;
  logic [AW-1:0] raddr;
  logic [7:0]    ram_rdata;
  logic          blank_p1;
  logic [2:0]    glyph_col_p1;
  logic [3:0]    glyph_row_p1;
  logic          vld_p1;

  assign in_vis = (pix_x < 10'(H_VIS)) && (pix_y < 10'(V_VIS));
  assign raddr  = in_vis ? cell_index(pix_y[8:4], pix_x[9:3]) : '0;

  text_buffer_ram #(
    .DEPTH(CELLS),
    .AW   (AW)
  ) u_ram (
    .clk  (clk),
    .we   (we & ~reset),
    .waddr(waddr),
    .wdata(wdata),
    .raddr(raddr),
    .rdata(ram_rdata)
  );

  // ---- stage p1: pixel-side outputs aligned with RAM read data ----
  always_ff @(posedge clk) begin
    if (reset) begin
      blank_p1     <= 1'b1;
      glyph_col_p1 <= '0;
      glyph_row_p1 <= '0;
      vld_p1       <= 1'b0;
    end else begin
      blank_p1     <= ~in_vis;
      glyph_col_p1 <= pix_x[2:0];
      glyph_row_p1 <= pix_y[3:0];
      vld_p1       <= video_on_in;
    end
  end

  assign char_code    = blank_p1 ? SPACE : ram_rdata;
  assign glyph_col    = glyph_col_p1;
  assign glyph_row    = glyph_row_p1;
  assign video_on_out = vld_p1;

`ifdef TEXT_CONSOLE_CURSOR_BLINK_EN
  localparam int FW = $clog2(BLINK_FRAMES + 1);
  logic [FW-1:0] frame_cnt;
  logic          phase;
  logic [6:0]    cell_col_p1;
  logic [4:0]    cell_row_p1;

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt <= '0;
      phase     <= 1'b1;
    end else if (frame_tick) begin
      if (frame_cnt == FW'(BLINK_FRAMES - 1)) begin
        frame_cnt <= '0;
        phase     <= ~phase;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    cell_col_p1 <= pix_x[9:3];
    cell_row_p1 <= pix_y[8:4];
  end

  assign cursor_hit = phase && (cell_col_p1 == cur_col) && (cell_row_p1 == cur_row)
                      && vld_p1 && ~busy;
`else
  logic unused_blink;
  assign unused_blink = ^{frame_tick, 32'(BLINK_FRAMES)};
  assign cursor_hit   = 1'b0;
`endif

endmodule

// File: tb/tb_text_console_ctrl.sv
// Directed testbench for text_console_ctrl: reset sweep, printing, wrap,
// bottom wrap, control codes, reset mid-clear and cursor blink.
module tb_text_console_ctrl;

  logic       clk;
  logic       reset;
  logic       wr_valid;
  logic [7:0] wr_char;
  logic       wr_ready;
  logic [9:0] pix_x;
  logic [9:0] pix_y;
  logic       video_on_in;
  logic       frame_tick;
  logic [7:0] char_code;
  logic [2:0] glyph_col;
  logic [3:0] glyph_row;
  logic       video_on_out;
  logic       cursor_hit;
  logic [6:0] cursor_col;
  logic [4:0] cursor_row;
  logic       busy;

  int total = 0;
  int bad   = 0;

  text_console_ctrl #(
    .COLS(80),
    .ROWS(30),
    .BLINK_FRAMES(2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .wr_valid    (wr_valid),
    .wr_char     (wr_char),
    .wr_ready    (wr_ready),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .video_on_in (video_on_in),
    .frame_tick  (frame_tick),
    .char_code   (char_code),
    .glyph_col   (glyph_col),
    .glyph_row   (glyph_row),
    .video_on_out(video_on_out),
    .cursor_hit  (cursor_hit),
    .cursor_col  (cursor_col),
    .cursor_row  (cursor_row),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    wr_valid = 1'b1;
    wr_char  = b;
    while (!wr_ready && n < 5000) begin
      tick();
      n++;
    end
    if (n >= 5000) check("send_ready_timeout", {31'd0, wr_ready}, 32'd1);
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic read_cell(input int c, input int r, output logic [7:0] ch);
    pix_x       = 10'(c * 8);
    pix_y       = 10'(r * 16);
    video_on_in = 1'b1;
    tick();
    ch = char_code;
  endtask

  task automatic row_mismatch(input int r, input logic [7:0] exp, output int nbad);
    logic [7:0] ch;
    nbad = 0;
    for (int c = 0; c < 80; c++) begin
      read_cell(c, r, ch);
      if (ch !== exp) nbad++;
    end
  endtask

  task automatic screen_nonspace(output int nbad);
    int rb;
    nbad = 0;
    for (int r = 0; r < 30; r++) begin
      row_mismatch(r, 8'h20, rb);
      nbad += rb;
    end
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 5000) begin
      tick();
      n++;
    end
  endtask

  task automatic pulse_frame();
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    tick();
  endtask

  logic [7:0] ch;
  int         n;
  logic       exp_blink;

  initial begin
`ifdef TEXT_CONSOLE_CURSOR_BLINK_EN
    exp_blink = 1'b1;
`else
    exp_blink = 1'b0;
`endif
    reset       = 1'b1;
    wr_valid    = 1'b0;
    wr_char     = 8'h00;
    pix_x       = 10'd13;
    pix_y       = 10'd7;
    video_on_in = 1'b1;
    frame_tick  = 1'b0;

    // Reset state
    repeat (3) tick();
    check("rst_wr_ready", {31'd0, wr_ready}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd1);
    check("rst_char_code", {24'd0, char_code}, 32'h20);
    check("rst_glyph_col", {29'd0, glyph_col}, 32'd0);
    check("rst_glyph_row", {28'd0, glyph_row}, 32'd0);
    check("rst_video_on_out", {31'd0, video_on_out}, 32'd0);
    check("rst_cursor_hit", {31'd0, cursor_hit}, 32'd0);
    check("rst_cursor_col", {25'd0, cursor_col}, 32'd0);
    check("rst_cursor_row", {27'd0, cursor_row}, 32'd0);

    reset = 1'b0;
    n = 0;
    while (!wr_ready && n < 5000) begin
      tick();
      n++;
    end
    check("reset_sweep_len", n, 32'd2400);
    screen_nonspace(n);
    check("reset_blank_screen", n, 32'd0);

    // Printable write and readback
    send(8'h48);
    send(8'h69);
    check("hi_cursor_col", {25'd0, cursor_col}, 32'd2);
    check("hi_cursor_row", {27'd0, cursor_row}, 32'd0);
    read_cell(1, 0, ch);
    check("hi_read_i", {24'd0, ch}, 32'h69);
    check("hi_glyph_col", {29'd0, glyph_col}, 32'd0);
    read_cell(0, 0, ch);
    check("hi_read_H", {24'd0, ch}, 32'h48);
    pix_x = 10'd13;
    pix_y = 10'd7;
    tick();
    check("pix_char", {24'd0, char_code}, 32'h69);
    check("pix_glyph_col", {29'd0, glyph_col}, 32'd5);
    check("pix_glyph_row", {28'd0, glyph_row}, 32'd7);
    check("pix_video_on", {31'd0, video_on_out}, 32'd1);
    video_on_in = 1'b0;
    tick();
    check("pix_video_off", {31'd0, video_on_out}, 32'd0);
    pix_x = 10'd640;
    pix_y = 10'd0;
    tick();
    check("oob_x_blank", {24'd0, char_code}, 32'h20);
    pix_x = 10'd0;
    pix_y = 10'd480;
    tick();
    check("oob_y_blank", {24'd0, char_code}, 32'h20);

    // Line wrap
    send(8'h0D);
    check("cr_col", {25'd0, cursor_col}, 32'd0);
    for (int i = 0; i < 79; i++) send(8'h41);
    check("wrap_col79", {25'd0, cursor_col}, 32'd79);
    send(8'h41);
    check("wrap_col", {25'd0, cursor_col}, 32'd0);
    check("wrap_row", {27'd0, cursor_row}, 32'd1);
    check("wrap_busy", {31'd0, busy}, 32'd1);
    wait_idle(n);
    check("wrap_busy_len", n, 32'd80);
    row_mismatch(1, 8'h20, n);
    check("wrap_row1_blank", n, 32'd0);
    row_mismatch(0, 8'h41, n);
    check("wrap_row0_A", n, 32'd0);

    // Bottom wrap
    for (int r = 1; r < 29; r++) begin
      send(8'(8'h30 + r));
      send(8'h0A);
    end
    send(8'h5A);
    check("bottom_pre_row", {27'd0, cursor_row}, 32'd29);
    send(8'h0A);
    check("bottom_col", {25'd0, cursor_col}, 32'd0);
    check("bottom_row", {27'd0, cursor_row}, 32'd0);
    wait_idle(n);
    check("bottom_busy_len", n, 32'd80);
    row_mismatch(0, 8'h20, n);
    check("bottom_row0_blank", n, 32'd0);
    read_cell(0, 29, ch);
    check("bottom_row29_Z", {24'd0, ch}, 32'h5A);
    read_cell(1, 29, ch);
    check("bottom_row29_sp", {24'd0, ch}, 32'h20);
    read_cell(0, 28, ch);
    check("bottom_row28", {24'd0, ch}, 32'h4C);

    // Control codes
    send(8'h61); send(8'h62); send(8'h63); send(8'h64); send(8'h65);
    check("bs_pre_col", {25'd0, cursor_col}, 32'd5);
    send(8'h08);
    check("bs_col", {25'd0, cursor_col}, 32'd4);
    read_cell(4, 0, ch);
    check("bs_erased", {24'd0, ch}, 32'h20);
    read_cell(3, 0, ch);
    check("bs_kept", {24'd0, ch}, 32'h64);
    send(8'h0D);
    check("cr2_col", {25'd0, cursor_col}, 32'd0);
    send(8'h08);
    check("bs0_col", {25'd0, cursor_col}, 32'd0);
    check("bs0_busy", {31'd0, busy}, 32'd0);
    read_cell(0, 0, ch);
    check("bs0_cell", {24'd0, ch}, 32'h61);
    send(8'h01);
    check("other_col", {25'd0, cursor_col}, 32'd0);
    read_cell(0, 0, ch);
    check("other_cell", {24'd0, ch}, 32'h61);
    send(8'h0A);
    wait_idle(n);
    send(8'h71);
    check("pre_ff_pos", {20'd0, cursor_row, cursor_col}, {20'd0, 5'd1, 7'd1});
    send(8'h0C);
    check("ff_pos", {20'd0, cursor_row, cursor_col}, 32'd0);
    check("ff_busy", {31'd0, busy}, 32'd1);
    wait_idle(n);
    check("ff_busy_len", n, 32'd2400);
    screen_nonspace(n);
    check("ff_blank_screen", n, 32'd0);

    // Reset mid-clear
    send(8'h78);
    send(8'h0C);
    repeat (1000) tick();
    check("mid_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    repeat (2) tick();
    check("mid_rst_ready", {31'd0, wr_ready}, 32'd0);
    reset = 1'b0;
    n = 0;
    while (!wr_ready && n < 5000) begin
      tick();
      n++;
    end
    check("mid_sweep_len", n, 32'd2400);
    read_cell(0, 0, ch);
    check("mid_cell0", {24'd0, ch}, 32'h20);

    // Cursor blink (cursor at 0,0, phase starts on)
    read_cell(0, 0, ch);
    check("blink_on0", {31'd0, cursor_hit}, {31'd0, exp_blink});
    read_cell(1, 0, ch);
    check("blink_other_cell", {31'd0, cursor_hit}, 32'd0);
    pulse_frame();
    read_cell(0, 0, ch);
    check("blink_one_tick", {31'd0, cursor_hit}, {31'd0, exp_blink});
    pulse_frame();
    read_cell(0, 0, ch);
    check("blink_off", {31'd0, cursor_hit}, 32'd0);
    pulse_frame();
    pulse_frame();
    read_cell(0, 0, ch);
    check("blink_on1", {31'd0, cursor_hit}, {31'd0, exp_blink});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/text_console_ctrl.md
Name: text_console_ctrl

Overview:
- Sequences writes into an on-chip character buffer and serves glyph codes to the pixel-level ASCII renderer.
- Writer side: the CPU/MMIO path, a stream of bytes over a valid/ready handshake. The block interprets control codes, tracks the cursor, and performs screen and row clears.
- Reader side: maps the VGA pixel coordinates to a cell and returns that cell's character one cycle later.
- Fixed glyph geometry: 8x16 pixels, 640x480 visible area.

Parameters:
- COLS, 80, text columns (COLS*8 = 640)
- ROWS, 30, text rows (ROWS*16 = 480)
- BLINK_FRAMES, 30, frames per cursor blink half-period (used only with the optional feature)

Ports:
- clk  in  1  pixel clock
- reset  in  1  reset, synchronous, active-high
- wr_valid  in  1  writer has a byte
- wr_char  in  8  byte to print or control code
- wr_ready  out  1  block can accept a byte this cycle
- pix_x  in  10  current pixel column
- pix_y  in  10  current pixel row
- video_on_in  in  1  visible-area flag aligned with pix_x/pix_y
- frame_tick  in  1  one-cycle pulse per frame; ignored without the feature
- char_code  out  8  character at the cell addressed one cycle earlier
- glyph_col  out  3  pix_x[2:0] delayed 1 cycle
- glyph_row  out  4  pix_y[3:0] delayed 1 cycle
- video_on_out  out  1  video_on_in delayed 1 cycle
- cursor_hit  out  1  delayed cell is the cursor cell and the blink phase is on
- cursor_col  out  7  current cursor column
- cursor_row  out  5  current cursor row
- busy  out  1  clear sweep in progress

Behaviour:
- Storage and addressing:
  - Buffer is COLS*ROWS bytes, dual-port.
  - Write port owned by the FSM; read port owned by the pixel path.
  - Cell index = row*COLS + col, computed without a multiplier by shift-add: row*64 + row*16.
- States:
  - CLR_SCREEN: writes 0x20 to one cell per cycle, from index 0 up to COLS*ROWS-1, then goes to IDLE.
  - IDLE: wr_ready=1; a byte is accepted when wr_valid && wr_ready, one per cycle.
  - CLR_ROW: writes 0x20 to the COLS cells of cursor_row, then goes to IDLE.
- Reset, any state, mid-sweep included:
  - State goes to CLR_SCREEN with the sweep index at 0.
  - Cursor goes to (0,0).
  - wr_ready=0, busy=1, char_code=0x20, glyph_col=0, glyph_row=0, video_on_out=0, cursor_hit=0.
  - After reset deasserts, busy stays high for exactly COLS*ROWS cycles (2400), then wr_ready=1.
- Byte handling in IDLE, all effects visible the cycle after acceptance:
  - 0x20-0x7E: write the byte at the cursor, then col+1.
    - At col = COLS-1: col goes to 0 and the row advances.
  - 0x0A (LF): col goes to 0 and the row advances.
  - 0x0D (CR): col goes to 0, row unchanged.
  - 0x08 (BS): if col>0, col-1 and write 0x20 at the new position; at col=0, no effect.
  - 0x0C (FF): cursor goes to (0,0), enter CLR_SCREEN.
  - Any other byte: accepted and discarded.
- Row advance:
  - row < ROWS-1: row+1 and enter CLR_ROW for the new row.
  - row = ROWS-1: wrap to row 0 and enter CLR_ROW for row 0.
  - In both cases the new row is blanked before any further write, and wr_ready=0 for COLS cycles.
- busy = (state != IDLE); wr_ready = ~busy && ~reset.
- Read path, latency 1:
  - Cell is selected by pix_x[9:3] and pix_y[8:4].
  - If pix_x >= 640 or pix_y >= 480, the next char_code is 0x20.
  - Pixel outputs are registered in the same stage so they stay mutually aligned.
  - Reads are not blocked by writes. A same-cell read/write collision returns the old data.

Optional Feature:
- Macro: TEXT_CONSOLE_CURSOR_BLINK_EN.
- When defined:
  - A frame counter counts frame_tick pulses up to BLINK_FRAMES-1, then wraps and toggles a phase bit.
  - Phase resets to 1.
  - cursor_hit = phase && (delayed cell == cursor cell) && video_on_out && ~busy.
- When undefined:
  - cursor_hit is tied to 0.
  - frame_tick is unused and no blink logic is synthesized.

Decomposition:
- Package text_console_pkg holds:
  - geometry constants: CHAR_W=8, CHAR_H=16, H_VIS=640, V_VIS=480;
  - the control-code constants (LF, CR, BS, FF, SPACE);
  - the FSM state enum {CLR_SCREEN, IDLE, CLR_ROW}.
- One sub-module: text_buffer_ram, a simple dual-port RAM with 1-cycle synchronous read, instantiated once.

Test Plan:
- Reset then idle:
  - Stimulus: hold reset 3 cycles, release.
  - Response: wr_ready=0 for exactly 2400 cycles, then 1; every cell reads 0x20; cursor at (0,0).
- Printable write and readback:
  - Stimulus: send 'H' (0x48) and 'i' (0x69).
  - Response: cursor_col=2; pix_x=8, pix_y=0 gives char_code=0x69 one cycle later, glyph_col=0.
- Line wrap:
  - Stimulus: send 80 x 'A'.
  - Response: cursor moves to (0,1); busy=1 for 80 cycles; row 1 reads all 0x20.
- Bottom wrap:
  - Stimulus: fill 30 rows, send LF on row 29.
  - Response: cursor moves to (0,0); row 0 reads all 0x20; row 29 content intact.
- Control codes:
  - Stimulus: BS at col 5, then CR, then FF.
  - Response: col goes 4, then 0, then 0; FF gives busy for 2400 cycles and a blank screen.
- Reset mid-clear, and the optional feature:
  - Stimulus: assert reset 1000 cycles into an FF sweep.
  - Response: a full 2400-cycle sweep restarts.
  - With TEXT_CONSOLE_CURSOR_BLINK_EN and BLINK_FRAMES=2: cursor_hit on the cursor cell toggles every 2 frame_ticks.
